// File: rtl/cpc_pi_mailbox_if.sv
// Bus bundle between the CPC Z80 IO port and the Raspberry Pi toggle handshake.
// The mailbox uses the slave view; the bus and Pi side use the master view.
interface cpc_pi_mailbox_if;
   logic [7:0] A_HI;
   logic       A0;
   logic       IOREQ_B;
   logic       RD_B;
   logic       WR_B;
   logic [7:0] DIN;
   logic [7:0] DOUT;
   logic       DOUT_EN;
   logic [7:0] PI_DATA;
   logic       PI_STB;
   logic       PI_ACK;
   logic [7:0] PI_WDATA;
   logic       PI_WSTB;
   logic       PI_WACK;

   modport master (
      output A_HI, A0, IOREQ_B, RD_B, WR_B, DIN, PI_ACK, PI_WDATA, PI_WSTB,
      input  DOUT, DOUT_EN, PI_DATA, PI_STB, PI_WACK
   );

   modport slave (
      input  A_HI, A0, IOREQ_B, RD_B, WR_B, DIN, PI_ACK, PI_WDATA, PI_WSTB,
      output DOUT, DOUT_EN, PI_DATA, PI_STB, PI_WACK
   );
endinterface

// File: rtl/cpc_pi_mailbox.sv
// Z80 IO-port mailbox: a Z80-to-Pi byte FIFO drained over a toggle handshake,
// plus a single-entry Pi-to-Z80 receive register with its own toggle handshake.
module cpc_pi_mailbox #(
   parameter int         DEPTH       = 8,
   parameter logic [7:0] PORT_ADDR   = 8'hFD,
   parameter int         SYNC_STAGES = 2
) (
   input logic              CLK,
   input logic              RESET,
   cpc_pi_mailbox_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {IDLE, PRESENT, WAIT_ACK} tx_state_t;

   tx_state_t             state;
   logic                  io_wr, io_rd;
   logic                  io_wr_q, io_wr_qq, io_rd_data_q, io_rd_data_qq;
   logic                  wr_fire, rd_fall;
   logic [SYNC_STAGES-1:0] ack_sync, wstb_sync;
   logic [7:0]            mem [DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [CW-1:0]         count;
   logic [6:0]            count_wide;
   logic [4:0]            count_field;
   logic                  full, push, pop, flush, ack_match;
   logic                  ovf, rx_full, drop;
   logic [7:0]            rx_reg, pi_data;
   logic                  pi_stb, pi_wack;

   assign io_wr = !bus.IOREQ_B && !bus.WR_B && (bus.A_HI == PORT_ADDR);
   assign io_rd = !bus.IOREQ_B && !bus.RD_B && (bus.A_HI == PORT_ADDR);

   assign wr_fire   = io_wr_q && !io_wr_qq;
   assign rd_fall   = !io_rd_data_q && io_rd_data_qq;
   assign full      = (count == CW'(DEPTH));
   assign flush     = wr_fire && bus.A0 && bus.DIN[0];
   assign push      = wr_fire && !bus.A0 && !full;
   assign ack_match = (ack_sync[SYNC_STAGES-1] == pi_stb);
   // A flush in the same cycle as the acknowledge discards the byte in flight.
   assign pop       = (state == WAIT_ACK) && ack_match && !drop && !flush;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         io_wr_q       <= 1'b0;
         io_wr_qq      <= 1'b0;
         io_rd_data_q  <= 1'b0;
         io_rd_data_qq <= 1'b0;
         ack_sync      <= '0;
         wstb_sync     <= '0;
      end else begin
         io_wr_q       <= io_wr;
         io_wr_qq      <= io_wr_q;
         io_rd_data_q  <= io_rd && !bus.A0;
         io_rd_data_qq <= io_rd_data_q;
         ack_sync      <= {ack_sync[SYNC_STAGES-2:0], bus.PI_ACK};
         wstb_sync     <= {wstb_sync[SYNC_STAGES-2:0], bus.PI_WSTB};
      end
   end

   always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr] <= bus.DIN;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET)
         ovf <= 1'b0;
      else if (wr_fire && !bus.A0 && full)
         ovf <= 1'b1;
      else if (wr_fire && bus.A0 && bus.DIN[1])
         ovf <= 1'b0;
   end

   // PRESENT re-checks occupancy so a flush racing the IDLE exit never shows a stale head.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= IDLE;
         pi_data <= 8'h00;
         pi_stb  <= 1'b0;
         drop    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (count != '0) state <= PRESENT;
            end
            PRESENT: begin
               if (flush || count == '0) begin
                  state <= IDLE;
               end else begin
                  pi_data <= mem[rd_ptr];
                  pi_stb  <= !pi_stb;
                  state   <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               if (ack_match) begin
                  drop  <= 1'b0;
                  state <= IDLE;
               end else if (flush) begin
                  drop <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         rx_reg  <= 8'h00;
         rx_full <= 1'b0;
         pi_wack <= 1'b0;
      end else if (rd_fall) begin
         rx_full <= 1'b0;
      end else if ((wstb_sync[SYNC_STAGES-1] != pi_wack) && !rx_full) begin
         rx_reg  <= bus.PI_WDATA;
         rx_full <= 1'b1;
         pi_wack <= !pi_wack;
      end
   end

   always_comb begin
      count_wide  = 7'(count);
      count_field = (count_wide > 7'd31) ? 5'd31 : count_wide[4:0];
   end

   assign bus.DOUT_EN = io_rd;
   assign bus.DOUT    = bus.A0 ? {ovf, rx_full, (count == '0), count_field} : rx_reg;
   assign bus.PI_DATA = pi_data;
   assign bus.PI_STB  = pi_stb;
   assign bus.PI_WACK = pi_wack;

endmodule

// File: tb/tb_cpc_pi_mailbox.sv
// Directed bench for cpc_pi_mailbox: Z80 port cycles and a Pi toggle-handshake model,
// with hand-computed expected status bytes, FIFO data order and strobe counts.
module tb_cpc_pi_mailbox;

   logic clk = 1'b0;
   logic reset = 1'b1;

   int   pass_count = 0;
   int   check_count = 0;
   int   fail_count = 0;
   int   stb_toggles = 0;
   int   wack_toggles = 0;
   logic stb_last = 1'b0;
   logic wack_last = 1'b0;
   logic [7:0] rd;
   logic       rd_en;

   always #5 clk = ~clk;

   cpc_pi_mailbox_if bus();

   cpc_pi_mailbox #(.DEPTH(8), .PORT_ADDR(8'hFD), .SYNC_STAGES(2)) dut (
      .CLK   (clk),
      .RESET (reset),
      .bus   (bus)
   );

   always @(negedge clk) begin
      if (bus.PI_STB !== stb_last) stb_toggles++;
      if (bus.PI_WACK !== wack_last) wack_toggles++;
      stb_last  = bus.PI_STB;
      wack_last = bus.PI_WACK;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      assert (observed === expected) pass_count = pass_count + 1;
      else begin
         fail_count++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // One Z80 IO cycle, entered and left on a falling clock edge.
   task automatic applyStimulus(input logic [7:0] a_hi, input logic a0, input logic is_write,
                                input logic [7:0] data, input logic ioreq,
                                output logic [7:0] rd_data, output logic rd_enable);
      bus.A_HI    = a_hi;
      bus.A0      = a0;
      bus.DIN     = data;
      bus.IOREQ_B = !ioreq;
      bus.WR_B    = !is_write;
      bus.RD_B    = is_write;
      @(negedge clk);
      rd_data   = bus.DOUT;
      rd_enable = bus.DOUT_EN;
      repeat (2) @(negedge clk);
      bus.IOREQ_B = 1'b1;
      bus.WR_B    = 1'b1;
      bus.RD_B    = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic z80_write(input logic [15:0] addr, input logic [7:0] data);
      logic [7:0] d;
      logic       e;
      applyStimulus(addr[15:8], addr[0], 1'b1, data, 1'b1, d, e);
   endtask

   task automatic z80_read(input logic [15:0] addr, output logic [7:0] data, output logic en);
      applyStimulus(addr[15:8], addr[0], 1'b0, 8'h00, 1'b1, data, en);
   endtask

   // Pi side: wait for a pending strobe, check the byte, then acknowledge after a delay.
   task automatic pi_take(input string tag, input logic [7:0] expected, input int delay);
      for (int n = 0; n < 60 && bus.PI_STB === bus.PI_ACK; n++) @(negedge clk);
      checkOutput({tag, "_stb"}, 32'(bus.PI_STB !== bus.PI_ACK), 32'd1);
      checkOutput({tag, "_data"}, 32'(bus.PI_DATA), 32'(expected));
      repeat (delay) @(negedge clk);
      bus.PI_ACK = bus.PI_STB;
   endtask

   task automatic wait_wack(input string tag, input logic expected);
      for (int n = 0; n < 30 && bus.PI_WACK !== bus.PI_WSTB; n++) @(negedge clk);
      checkOutput(tag, 32'(bus.PI_WACK), 32'(expected));
   endtask

   initial begin
      bus.A_HI     = 8'h00;
      bus.A0       = 1'b0;
      bus.IOREQ_B  = 1'b1;
      bus.RD_B     = 1'b1;
      bus.WR_B     = 1'b1;
      bus.DIN      = 8'h00;
      bus.PI_ACK   = 1'b0;
      bus.PI_WDATA = 8'h00;
      bus.PI_WSTB  = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] reset state");
      checkOutput("rst_pi_stb", 32'(bus.PI_STB), 32'd0);
      checkOutput("rst_pi_wack", 32'(bus.PI_WACK), 32'd0);
      checkOutput("rst_pi_data", 32'(bus.PI_DATA), 32'd0);
      checkOutput("rst_dout_en_idle", 32'(bus.DOUT_EN), 32'd0);
      z80_read(16'hFD01, rd, rd_en);
      checkOutput("rst_status", 32'(rd), 32'h20);
      checkOutput("rst_status_en", 32'(rd_en), 32'd1);
      z80_read(16'hFD00, rd, rd_en);
      checkOutput("rst_rx_reg", 32'(rd), 32'h00);

      $display("[TB] push and drain");
      stb_toggles = 0;
      bus.A_HI = 8'hFD; bus.A0 = 1'b0; bus.DIN = 8'h11; bus.IOREQ_B = 1'b0; bus.WR_B = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("lat_before", 32'(bus.PI_STB), 32'd0);
      @(negedge clk);
      checkOutput("lat_toggle", 32'(bus.PI_STB), 32'd1);
      checkOutput("lat_data", 32'(bus.PI_DATA), 32'h11);
      bus.IOREQ_B = 1'b1; bus.WR_B = 1'b1;
      repeat (3) @(negedge clk);
      z80_write(16'hFD00, 8'h22);
      z80_write(16'hFD00, 8'h33);
      pi_take("drain0", 8'h11, 0);
      pi_take("drain1", 8'h22, 0);
      pi_take("drain2", 8'h33, 0);
      repeat (10) @(negedge clk);
      checkOutput("drain_toggles", 32'(stb_toggles), 32'd3);
      z80_read(16'hFD01, rd, rd_en);
      checkOutput("drain_status", 32'(rd), 32'h20);

      $display("[TB] full and overflow");
      for (int i = 0; i < 9; i++) z80_write(16'hFD00, 8'(8'h01 + i));
      z80_read(16'hFD01, rd, rd_en);
      checkOutput("ovf_status", 32'(rd), 32'h88);
      checkOutput("ovf_head", 32'(bus.PI_DATA), 32'h01);
      z80_write(16'hFD01, 8'h02);
      z80_read(16'hFD01, rd, rd_en);
      checkOutput("ovf_cleared", 32'(rd), 32'h08);
      z80_write(16'hFD01, 8'h01);
      bus.PI_ACK = bus.PI_STB;
      repeat (10) @(negedge clk);
      z80_read(16'hFD01, rd, rd_en);
      checkOutput("ovf_flushed", 32'(rd), 32'h20);

      $display("[TB] flush in flight");
      z80_write(16'hFD00, 8'hA1);
      z80_write(16'hFD00, 8'hA2);
      checkOutput("fif_pending", 32'(bus.PI_STB !== bus.PI_ACK), 32'd1);
      checkOutput("fif_head", 32'(bus.PI_DATA), 32'hA1);
      z80_write(16'hFD01, 8'h01);
      z80_write(16'hFD00, 8'hAB);
      z80_read(16'hFD01, rd, rd_en);
      checkOutput("fif_count_after_push", 32'(rd), 32'h01);
      bus.PI_ACK = bus.PI_STB;
      repeat (8) @(negedge clk);
      z80_read(16'hFD01, rd, rd_en);
      checkOutput("fif_no_pop", 32'(rd), 32'h01);
      pi_take("fif_next", 8'hAB, 0);
      repeat (10) @(negedge clk);
      z80_read(16'hFD01, rd, rd_en);
      checkOutput("fif_status", 32'(rd), 32'h20);

      $display("[TB] rx hold-off");
      wack_toggles = 0;
      bus.PI_WDATA = 8'h5A;
      bus.PI_WSTB  = 1'b1;
      wait_wack("rx_first_ack", 1'b1);
      bus.PI_WDATA = 8'hC3;
      bus.PI_WSTB  = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("rx_holdoff_wack", 32'(bus.PI_WACK), 32'd1);
      checkOutput("rx_holdoff_toggles", 32'(wack_toggles), 32'd1);
      z80_read(16'hFD01, rd, rd_en);
      checkOutput("rx_full_status", 32'(rd), 32'h60);
      z80_read(16'hFD00, rd, rd_en);
      checkOutput("rx_first_byte", 32'(rd), 32'h5A);
      wait_wack("rx_second_ack", 1'b0);
      @(negedge clk);
      checkOutput("rx_toggles", 32'(wack_toggles), 32'd2);
      z80_read(16'hFD00, rd, rd_en);
      checkOutput("rx_second_byte", 32'(rd), 32'hC3);
      z80_read(16'hFD01, rd, rd_en);
      checkOutput("rx_status_after", 32'(rd), 32'h20);

      $display("[TB] stream with wrap");
      stb_toggles = 0;
      fork
         begin
            for (int i = 0; i < 20; i++) z80_write(16'hFD00, 8'(8'h80 + i));
         end
         begin
            for (int j = 0; j < 20; j++) pi_take("stream", 8'(8'h80 + j), j % 3);
         end
      join
      repeat (10) @(negedge clk);
      checkOutput("stream_toggles", 32'(stb_toggles), 32'd20);
      z80_read(16'hFD01, rd, rd_en);
      checkOutput("stream_status", 32'(rd), 32'h20);

      $display("[TB] decode miss");
      z80_write(16'hFE00, 8'h77);
      applyStimulus(8'hFD, 1'b0, 1'b1, 8'h78, 1'b0, rd, rd_en);
      repeat (6) @(negedge clk);
      checkOutput("miss_no_strobe", 32'(bus.PI_STB !== bus.PI_ACK), 32'd0);
      z80_read(16'hFE01, rd, rd_en);
      checkOutput("miss_read_en", 32'(rd_en), 32'd0);
      z80_read(16'hFD01, rd, rd_en);
      checkOutput("miss_status", 32'(rd), 32'h20);

      $display("[TB] reset mid handshake");
      z80_write(16'hFD00, 8'h31);
      z80_write(16'hFD00, 8'h32);
      checkOutput("rst_pre_stb", 32'(bus.PI_STB), 32'd1);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      bus.PI_ACK = 1'b0;
      @(negedge clk);
      checkOutput("rst_mid_stb", 32'(bus.PI_STB), 32'd0);
      checkOutput("rst_mid_data", 32'(bus.PI_DATA), 32'd0);
      repeat (10) @(negedge clk);
      checkOutput("rst_mid_stb_quiet", 32'(bus.PI_STB), 32'd0);
      z80_read(16'hFD01, rd, rd_en);
      checkOutput("rst_mid_status", 32'(rd), 32'h20);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/cpc_pi_mailbox.md
CPC_PI_MAILBOX -- requirements
Module: cpc_pi_mailbox

Interface
REQ-001 SHALL have parameter DEPTH, default 8, Z80-to-Pi FIFO entries (power of 2, 2..64).
REQ-002 SHALL have parameter PORT_ADDR, default 8'hFD, IO port upper address byte decoded on A15:A8.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, flops on each Pi-side asynchronous input (2..3).
REQ-004 SHALL have one clock and a synchronous, active-high reset, with ports listed first.
REQ-005 CLK  in  1  CPC bus clock (4 MHz); all state on rising edge.
REQ-006 RESET  in  1  synchronous, active-high reset.
REQ-007 A_HI  in  8  Z80 A15:A8.
REQ-008 A0  in  1  Z80 A0 (0 = data register, 1 = control/status register).
REQ-009 IOREQ_B, RD_B, WR_B  in  1 each  Z80 strobes, active low.
REQ-010 DIN  in  8  Z80 data bus, input.
REQ-011 DOUT  out  8  read data to the Z80 bus.
REQ-012 DOUT_EN  out  1  bus driver enable for DOUT.
REQ-013 PI_DATA  out  8  FIFO head byte presented to the Pi.
REQ-014 PI_STB  out  1  toggle marking a new PI_DATA byte.
REQ-015 PI_ACK  in  1  asynchronous toggle from the Pi acknowledging PI_STB.
REQ-016 PI_WDATA  in  8  Pi-to-Z80 byte, held stable by the Pi until PI_WACK toggles.
REQ-017 PI_WSTB  in  1  asynchronous toggle marking a new PI_WDATA byte.
REQ-018 PI_WACK  out  1  toggle acknowledging capture of PI_WDATA.

Function
REQ-019 Decode: io_wr = !IOREQ_B & !WR_B & (A_HI==PORT_ADDR); io_rd the same with RD_B; both registered once; action SHALL fire on the first cycle the registered term is high (rising edge), once per bus cycle.
REQ-020 Write with A0=0: push DIN when count<DEPTH; when full, drop the byte and set sticky OVF.
REQ-021 Write with A0=1: DIN[0]=1 flushes FIFO (pointers and count to 0); DIN[1]=1 clears OVF; other bits ignored.
REQ-022 Read: DOUT_EN SHALL be combinational io_rd; A0=0 gives DOUT=RX_REG; A0=1 gives DOUT={OVF, RX_FULL, TX_EMPTY, count[4:0]}, where count saturates at 31 in the field.
REQ-023 A data read (A0=0) SHALL clear RX_FULL on the falling edge of registered io_rd.
REQ-024 Count SHALL stay unchanged on a simultaneous push and pop; a push on full SHALL be dropped even when a pop occurs in the same cycle; pointers SHALL wrap modulo DEPTH.
REQ-025 TX state machine: IDLE -> PRESENT when the FIFO is non-empty.
REQ-026 PRESENT (one cycle): PI_DATA <= head, PI_STB toggles, then -> WAIT_ACK.
REQ-027 WAIT_ACK: when the synced PI_ACK equals PI_STB, pop (unless DROP is set), clear DROP, -> IDLE.
REQ-028 Flush during WAIT_ACK SHALL set DROP, leave state and PI_STB unchanged, and allow new pushes; the later acknowledge SHALL NOT pop.
REQ-029 RX path: the synced PI_WSTB differing from PI_WACK with RX_FULL=0 SHALL latch PI_WDATA into RX_REG, set RX_FULL, and toggle PI_WACK in the same cycle.
REQ-030 When RX_FULL=1, a pending PI_WSTB SHALL wait with no capture and no acknowledge until RX_FULL clears.
REQ-031 Minimum latency: push to PI_STB toggle 2 cycles; synced PI_WSTB to PI_WACK 1 cycle.

Reset
REQ-032 RESET high on a rising edge SHALL force: state IDLE, count/pointers 0, OVF=0, RX_FULL=0, DROP=0, RX_REG=0, PI_DATA=0, PI_STB=0, PI_WACK=0, and all synchroniser and edge flops to 0.
REQ-033 Reset mid-handshake SHALL abandon it without a further PI_STB toggle; the Pi SHALL re-align to PI_STB=0.
REQ-034 FIFO storage contents need not be reset.

Verification
REQ-035 Push and drain: write 8'h11, 8'h22, 8'h33 to port FD00, with the Pi acking each toggle -> PI_DATA sequence 11, 22, 33; PI_STB toggles 3 times; status reads 8'h20.
REQ-036 Full/overflow (DEPTH=8): 9 writes with no ack -> count 8, OVF=1, status 8'h88; write 8'h02 to FD01 -> OVF=0.
REQ-037 Flush in flight: 2 pushes, flush while WAIT_ACK, push 8'hAB, then ack -> no pop, next PI_DATA=AB.
REQ-038 RX hold-off: Pi sends 8'h5A then 8'hC3 -> one PI_WACK toggle only; FD00 read returns 5A; then C3 is captured; second read returns C3.
REQ-039 Wrap and simultaneous events: 20 bytes streamed with a push coinciding with a pop -> order preserved, count never exceeds 8.
REQ-040 Decode miss: write to FE00 or with IOREQ_B high -> no push; reset mid-WAIT_ACK -> PI_STB=0, count 0.
